mii_phy_mgmt_ctrl: RTL and testbench
====================================

// Module: mii_phy_mgmt_ctrl
// PURPOSE
//  Power-up and management sequencer for the 100BASE-T MII PHY: drives the PHY hardware reset, configures it
//  over MDIO (Clause 22), then polls BMSR for link state. Sits beside fpga_core in the board top level and
//  owns the PHY reset pin and MDC/MDIO pads; link status feeds board LEDs and the core.
// PARAMETERS
//  MDC_DIV           25          clk cycles per MDC half-period (125 MHz -> 2.5 MHz MDC); >=1
//  PHY_ADDR          5'd0        Clause 22 PHY address
//  BMCR_VALUE        16'h1200    value written to reg 0 (BMCR): autoneg enable + restart autoneg
//  RESET_CYCLES      125000      clk cycles o_phy_reset_n held low (1 ms)
//  POST_RESET_CYCLES 625000      clk cycles waited after reset release before first MDIO frame (5 ms)
//  POLL_CYCLES       12500000    idle clk cycles between successive BMSR reads (100 ms)
// PORTS
//  clk            in   1   system clock
//  rst            in   1   synchronous reset, active high
//  i_restart      in   1   single-cycle pulse: abort and rerun the full sequence
//  o_phy_reset_n  out  1   PHY hardware reset, active low
//  o_mdc          out  1   MDIO clock
//  o_mdio_o       out  1   MDIO output data (to tristate buffer)
//  o_mdio_oe      out  1   MDIO output enable, 1 = FPGA drives
//  i_mdio_i       in   1   MDIO input data (pre-synchronised by pad logic)
//  o_cfg_done     out  1   1 once BMCR write frame has completed; cleared by rst/i_restart
//  o_link_up      out  1   BMSR[2] from most recent completed read
//  o_bmsr         out  16  most recent BMSR value
// BEHAVIOUR
//  Reset values: o_phy_reset_n=0, o_mdc=0, o_mdio_o=1, o_mdio_oe=0, o_cfg_done=0, o_link_up=0, o_bmsr=0.
//  FSM: PHY_RST -> PHY_WAIT -> WR_BMCR -> POLL_WAIT -> RD_BMSR -> POLL_WAIT ...
//   PHY_RST: o_phy_reset_n=0 for exactly RESET_CYCLES clks, then 1 from the next cycle onward.
//   PHY_WAIT: POST_RESET_CYCLES clks, then WR_BMCR.
//   WR_BMCR: one write frame (OP=01, REGAD=0, data=BMCR_VALUE); at frame end o_cfg_done=1 -> POLL_WAIT.
//   POLL_WAIT: POLL_CYCLES clks (0 allowed = immediate), then RD_BMSR.
//   RD_BMSR: one read frame (OP=10, REGAD=1); at frame end o_bmsr<=captured data, o_link_up<=data[2].
//  Frame: 64 bit periods, each 2*MDC_DIV clks. Bits 0-31 preamble (1), 32-33 ST=01, 34-35 OP, 36-40 PHYAD
//   MSB first, 41-45 REGAD MSB first, 46-47 TA, 48-63 data MSB first.
//  Bit period: o_mdc low for first MDC_DIV clks, high for last MDC_DIV. o_mdio_o/o_mdio_oe update only
//   on the clk where o_mdc goes (or stays) low at period start; i_mdio_i sampled on the clk o_mdc rises.
//  Write: o_mdio_oe=1 bits 0-63, TA = 1,0. Read: o_mdio_oe=1 bits 0-45, 0 for bits 46-63; TA not checked.
//  After bit 63: o_mdc=0, o_mdio_oe=0, o_mdio_o=1 for one full bit period before leaving the state.
//  Outside frames: o_mdc=0, o_mdio_oe=0, o_mdio_o=1.
//  i_restart (any state, incl. mid-frame): next clk enters PHY_RST with all counters cleared, o_mdc=0,
//   o_mdio_oe=0, o_mdio_o=1, o_phy_reset_n=0, o_cfg_done=0, o_link_up=0; o_bmsr retained.
//   rst and i_restart together: rst wins (o_bmsr also cleared).
//  Partial frames never update o_bmsr/o_link_up. Counters are sized with $clog2 of their parameters;
//   no wrap-around in any counter (each reloads on state entry).
// TESTING  (MDC_DIV=2, RESET_CYCLES=10, POST_RESET_CYCLES=20, POLL_CYCLES=50, PHY_ADDR=5'd3)
//  1 Release rst -> o_phy_reset_n low exactly 10 clks, high thereafter; first o_mdc rise 22-24 clks later.
//  2 Write frame decoded at o_mdc rises = 32x'1',01,01,00011,00000,10,0x1200; o_cfg_done=1 after 1 idle bit.
//  3 PHY model returns 0x786D in read -> o_bmsr=16'h786D, o_link_up=1; next read 0x7869 -> o_link_up=0.
//  4 Read frame: o_mdio_oe falls at start of bit 46, stays 0 through bit 63; gap between reads = 50 clks + idle bit.
//  5 i_restart mid-read at bit 52 -> next clk o_mdio_oe=0, o_phy_reset_n=0, o_link_up=0, o_bmsr unchanged; sequence reruns from 1.
//  6 POLL_CYCLES=0 -> back-to-back read frames separated only by the 1-bit idle period.

Source files
------------

// File: rtl/mii_phy_mgmt_ctrl.sv
// mii_phy_mgmt_ctrl
// Brings the MII PHY out of hardware reset, writes BMCR once over Clause 22
// MDIO, then keeps polling BMSR and publishes the latest value and link bit.
// All outputs come straight from registers. The FSM is split into a register
// process and a combinational next-value process.
// RESET_CYCLES and MDC_DIV must be at least 1. POST_RESET_CYCLES and
// POLL_CYCLES may be 0; a value of 0 skips the corresponding wait state.

module mii_phy_mgmt_ctrl #(
    parameter int unsigned MDC_DIV           = 25,
    parameter logic [4:0]  PHY_ADDR          = 5'd0,
    parameter logic [15:0] BMCR_VALUE        = 16'h1200,
    parameter int unsigned RESET_CYCLES      = 125000,
    parameter int unsigned POST_RESET_CYCLES = 625000,
    parameter int unsigned POLL_CYCLES       = 12500000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        i_restart,
    output logic        o_phy_reset_n,
    output logic        o_mdc,
    output logic        o_mdio_o,
    output logic        o_mdio_oe,
    input  logic        i_mdio_i,
    output logic        o_cfg_done,
    output logic        o_link_up,
    output logic [15:0] o_bmsr
);

    // One shared wait counter serves all three wait states. It is sized for
    // the longest wait and reloaded to zero on every state entry, so it never
    // wraps.
    localparam int unsigned WAIT_MAX_A = (RESET_CYCLES > POST_RESET_CYCLES) ? RESET_CYCLES : POST_RESET_CYCLES;
    localparam int unsigned WAIT_MAX   = (WAIT_MAX_A > POLL_CYCLES) ? WAIT_MAX_A : POLL_CYCLES;
    localparam int unsigned WAIT_W     = (WAIT_MAX > 1) ? $clog2(WAIT_MAX) : 1;
    localparam int unsigned CLK_W      = $clog2(2 * MDC_DIV);

    localparam logic [WAIT_W-1:0] WAIT_ZERO  = WAIT_W'(0);
    localparam logic [WAIT_W-1:0] WAIT_ONE   = WAIT_W'(1);
    localparam logic [WAIT_W-1:0] RST_LAST   = WAIT_W'(RESET_CYCLES - 1);
    localparam logic [WAIT_W-1:0] PWAIT_LAST = WAIT_W'(POST_RESET_CYCLES - 1);
    localparam logic [WAIT_W-1:0] POLL_LAST  = WAIT_W'(POLL_CYCLES - 1);

    localparam logic [CLK_W-1:0] CLK_ZERO  = CLK_W'(0);
    localparam logic [CLK_W-1:0] CLK_ONE   = CLK_W'(1);
    localparam logic [CLK_W-1:0] HALF_LAST = CLK_W'(MDC_DIV - 1);
    localparam logic [CLK_W-1:0] PER_LAST  = CLK_W'(2 * MDC_DIV - 1);

    // Bit 64 is the trailing idle bit period that follows every frame.
    localparam logic [6:0] BIT_IDLE = 7'd64;

    typedef enum logic [2:0] {
        ST_PHY_RST   = 3'd0,
        ST_PHY_WAIT  = 3'd1,
        ST_WR_BMCR   = 3'd2,
        ST_POLL_WAIT = 3'd3,
        ST_RD_BMSR   = 3'd4
    } state_t;

    state_t            state_r, state_s;
    logic [WAIT_W-1:0] wait_cnt_r, wait_cnt_s;
    logic [CLK_W-1:0]  clk_cnt_r, clk_cnt_s;
    logic [6:0]        bit_cnt_r, bit_cnt_s;
    logic [15:0]       shift_r, shift_s;
    logic              mdc_r, mdc_s;
    logic              mdio_o_r, mdio_o_s;
    logic              mdio_oe_r, mdio_oe_s;
    logic              phy_reset_n_r, phy_reset_n_s;
    logic              cfg_done_r, cfg_done_s;
    logic              link_up_r, link_up_s;
    logic [15:0]       bmsr_r, bmsr_s;
    logic              start_wr_s, start_rd_s;

    // Returns {oe, o} for frame bit bit_idx. Indices above 63 give the idle
    // levels. In a read frame the pads are released from TA onward.
    function automatic logic [1:0] bit_drive(input logic is_wr, input logic [6:0] bit_idx);
        logic [63:0] frame;
        logic [5:0]  pos;
        logic        oe;
        logic [1:0]  res;
        if (is_wr) begin
            frame = {32'hFFFF_FFFF, 2'b01, 2'b01, PHY_ADDR, 5'd0, 2'b10, BMCR_VALUE};
        end else begin
            frame = {32'hFFFF_FFFF, 2'b01, 2'b10, PHY_ADDR, 5'd1, 2'b11, 16'hFFFF};
        end
        pos = 6'd63 - bit_idx[5:0];
        if (bit_idx > 7'd63) begin
            res = 2'b01;
        end else begin
            oe  = is_wr | (bit_idx < 7'd46);
            res = {oe, (oe ? frame[pos] : 1'b1)};
        end
        return res;
    endfunction

    // State and output registers. rst clears everything, including o_bmsr.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r       <= ST_PHY_RST;
            wait_cnt_r    <= WAIT_ZERO;
            clk_cnt_r     <= CLK_ZERO;
            bit_cnt_r     <= 7'd0;
            shift_r       <= 16'h0000;
            mdc_r         <= 1'b0;
            mdio_o_r      <= 1'b1;
            mdio_oe_r     <= 1'b0;
            phy_reset_n_r <= 1'b0;
            cfg_done_r    <= 1'b0;
            link_up_r     <= 1'b0;
            bmsr_r        <= 16'h0000;
        end else begin
            state_r       <= state_s;
            wait_cnt_r    <= wait_cnt_s;
            clk_cnt_r     <= clk_cnt_s;
            bit_cnt_r     <= bit_cnt_s;
            shift_r       <= shift_s;
            mdc_r         <= mdc_s;
            mdio_o_r      <= mdio_o_s;
            mdio_oe_r     <= mdio_oe_s;
            phy_reset_n_r <= phy_reset_n_s;
            cfg_done_r    <= cfg_done_s;
            link_up_r     <= link_up_s;
            bmsr_r        <= bmsr_s;
        end
    end

    // Next-state and next-output logic: wait counting, MDC generation, bit
    // shifting, and frame-completion bookkeeping.
    always_comb begin
        state_s       = state_r;
        wait_cnt_s    = wait_cnt_r;
        clk_cnt_s     = clk_cnt_r;
        bit_cnt_s     = bit_cnt_r;
        shift_s       = shift_r;
        mdc_s         = mdc_r;
        mdio_o_s      = mdio_o_r;
        mdio_oe_s     = mdio_oe_r;
        phy_reset_n_s = phy_reset_n_r;
        cfg_done_s    = cfg_done_r;
        link_up_s     = link_up_r;
        bmsr_s        = bmsr_r;
        start_wr_s    = 1'b0;
        start_rd_s    = 1'b0;

        if (i_restart) begin
            // Abort: the sequence restarts from PHY reset. o_bmsr keeps its value.
            state_s       = ST_PHY_RST;
            wait_cnt_s    = WAIT_ZERO;
            clk_cnt_s     = CLK_ZERO;
            bit_cnt_s     = 7'd0;
            shift_s       = 16'h0000;
            mdc_s         = 1'b0;
            mdio_o_s      = 1'b1;
            mdio_oe_s     = 1'b0;
            phy_reset_n_s = 1'b0;
            cfg_done_s    = 1'b0;
            link_up_s     = 1'b0;
        end else begin
            case (state_r)
                ST_PHY_RST: begin
                    phy_reset_n_s = 1'b0;
                    if (wait_cnt_r == RST_LAST) begin
                        phy_reset_n_s = 1'b1;
                        wait_cnt_s    = WAIT_ZERO;
                        if (POST_RESET_CYCLES == 0) begin
                            start_wr_s = 1'b1;
                        end else begin
                            state_s = ST_PHY_WAIT;
                        end
                    end else begin
                        wait_cnt_s = wait_cnt_r + WAIT_ONE;
                    end
                end

                ST_PHY_WAIT: begin
                    if (wait_cnt_r == PWAIT_LAST) begin
                        start_wr_s = 1'b1;
                    end else begin
                        wait_cnt_s = wait_cnt_r + WAIT_ONE;
                    end
                end

                ST_POLL_WAIT: begin
                    if (wait_cnt_r == POLL_LAST) begin
                        start_rd_s = 1'b1;
                    end else begin
                        wait_cnt_s = wait_cnt_r + WAIT_ONE;
                    end
                end

                ST_WR_BMCR, ST_RD_BMSR: begin
                    if (clk_cnt_r == HALF_LAST) begin
                        // MDC rises here, except during the idle bit, when
                        // it stays low. Read data is sampled on this clock.
                        mdc_s     = (bit_cnt_r != BIT_IDLE);
                        clk_cnt_s = clk_cnt_r + CLK_ONE;
                        if ((state_r == ST_RD_BMSR) && (bit_cnt_r >= 7'd48) && (bit_cnt_r <= 7'd63)) begin
                            shift_s = {shift_r[14:0], i_mdio_i};
                        end else begin
                            shift_s = shift_r;
                        end
                    end else if (clk_cnt_r == PER_LAST) begin
                        mdc_s     = 1'b0;
                        clk_cnt_s = CLK_ZERO;
                        if (bit_cnt_r == BIT_IDLE) begin
                            // A full frame has completed, including the idle bit.
                            if (state_r == ST_WR_BMCR) begin
                                cfg_done_s = 1'b1;
                            end else begin
                                bmsr_s    = shift_r;
                                link_up_s = shift_r[2];
                            end
                            if (POLL_CYCLES == 0) begin
                                start_rd_s = 1'b1;
                            end else begin
                                state_s    = ST_POLL_WAIT;
                                wait_cnt_s = WAIT_ZERO;
                            end
                        end else begin
                            bit_cnt_s              = bit_cnt_r + 7'd1;
                            {mdio_oe_s, mdio_o_s}  = bit_drive(state_r == ST_WR_BMCR, bit_cnt_r + 7'd1);
                        end
                    end else begin
                        clk_cnt_s = clk_cnt_r + CLK_ONE;
                    end
                end

                default: begin
                    state_s       = ST_PHY_RST;
                    wait_cnt_s    = WAIT_ZERO;
                    mdc_s         = 1'b0;
                    mdio_o_s      = 1'b1;
                    mdio_oe_s     = 1'b0;
                    phy_reset_n_s = 1'b0;
                end
            endcase

            // Frame launch: bit 0 is driven on the entry clock, with MDC low.
            if (start_wr_s || start_rd_s) begin
                state_s               = start_wr_s ? ST_WR_BMCR : ST_RD_BMSR;
                wait_cnt_s            = WAIT_ZERO;
                clk_cnt_s             = CLK_ZERO;
                bit_cnt_s             = 7'd0;
                shift_s               = 16'h0000;
                mdc_s                 = 1'b0;
                {mdio_oe_s, mdio_o_s} = bit_drive(start_wr_s, 7'd0);
            end else begin
                state_s = state_s;
            end
        end
    end

    assign o_phy_reset_n = phy_reset_n_r;
    assign o_mdc         = mdc_r;
    assign o_mdio_o      = mdio_o_r;
    assign o_mdio_oe     = mdio_oe_r;
    assign o_cfg_done    = cfg_done_r;
    assign o_link_up     = link_up_r;
    assign o_bmsr        = bmsr_r;

endmodule

// File: tb/tb_mii_phy_mgmt_ctrl.sv
// tb_mii_phy_mgmt_ctrl
// Directed bench for the MII PHY management sequencer. The main instance uses
// a 50-cycle poll gap. A second instance uses POLL_CYCLES=0 to exercise
// back-to-back reads. A negedge monitor decodes frames at the MDC rises and
// models the PHY data returned during reads.

module tb_mii_phy_mgmt_ctrl;

    localparam int D = 2;

    logic        clk = 1'b0;
    logic        rst;
    logic        restart;
    logic        mdio_in;
    logic        phy_reset_n, mdc, mdio_o, mdio_oe, cfg_done, link_up;
    logic [15:0] bmsr;
    logic        phy_reset_n2, mdc2, mdio_o2, mdio_oe2, cfg_done2, link_up2;
    logic [15:0] bmsr2;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    mii_phy_mgmt_ctrl #(
        .MDC_DIV(2), .PHY_ADDR(5'd3), .BMCR_VALUE(16'h1200),
        .RESET_CYCLES(10), .POST_RESET_CYCLES(20), .POLL_CYCLES(50)
    ) dut (
        .clk(clk), .rst(rst), .i_restart(restart), .o_phy_reset_n(phy_reset_n),
        .o_mdc(mdc), .o_mdio_o(mdio_o), .o_mdio_oe(mdio_oe), .i_mdio_i(mdio_in),
        .o_cfg_done(cfg_done), .o_link_up(link_up), .o_bmsr(bmsr)
    );

    mii_phy_mgmt_ctrl #(
        .MDC_DIV(2), .PHY_ADDR(5'd3), .BMCR_VALUE(16'h1200),
        .RESET_CYCLES(10), .POST_RESET_CYCLES(20), .POLL_CYCLES(0)
    ) dut0 (
        .clk(clk), .rst(rst), .i_restart(restart), .o_phy_reset_n(phy_reset_n2),
        .o_mdc(mdc2), .o_mdio_o(mdio_o2), .o_mdio_oe(mdio_oe2), .i_mdio_i(1'b1),
        .o_cfg_done(cfg_done2), .o_link_up(link_up2), .o_bmsr(bmsr2)
    );

    always #5 clk = ~clk;

    // Free-running cycle count used to time frame starts.
    always @(posedge clk) cyc <= cyc + 1;

    // Frame monitor for the main DUT. Bit index advances on each MDC rise; a
    // long low gap marks the start of a new frame.
    logic [15:0] phy_data = 16'h0000;
    logic [63:0] cap_o, cap_oe, last_o, last_oe;
    int          idx = 0, gap = 1000, frame_cnt = 0, rise0_last = 0, rise0_prev = 0;
    logic        prev_mdc = 1'b0;

    // Records mdio_o and mdio_oe at each MDC rise and counts completed frames.
    always @(negedge clk) begin : mon
        int k;
        if (mdc && !prev_mdc) begin
            k = (gap >= 2 * D) ? 0 : idx + 1;
            idx <= k;
            gap <= 0;
            if (k <= 63) begin
                cap_o[63 - k]  <= mdio_o;
                cap_oe[63 - k] <= mdio_oe;
            end
            if (k == 0) begin
                rise0_prev <= rise0_last;
                rise0_last <= cyc;
            end
            if (k == 63) begin
                last_o    <= {cap_o[63:1], mdio_o};
                last_oe   <= {cap_oe[63:1], mdio_oe};
                frame_cnt <= frame_cnt + 1;
            end
        end else begin
            gap <= gap + 1;
        end
        prev_mdc <= mdc;
    end

    // PHY model: presents data bit n before the MDC rise of bit n (bits 48-63, MSB first).
    always_comb begin
        int nx;
        nx = (gap >= 2 * D) ? 0 : idx + 1;
        if (nx >= 48 && nx <= 63) mdio_in = phy_data[63 - nx];
        else mdio_in = 1'b1;
    end

    // Records the cycle of each frame start on the POLL_CYCLES=0 instance.
    int   starts2 [3];
    int   n2 = 0, gap2 = 1000;
    logic prev2 = 1'b0;
    always @(negedge clk) begin
        if (mdc2 && !prev2) begin
            if (gap2 >= 2 * D) begin
                if (n2 < 3) starts2[n2] <= cyc;
                n2 <= n2 + 1;
            end
            gap2 <= 0;
        end else begin
            gap2 <= gap2 + 1;
        end
        prev2 <= mdc2;
    end

    typedef struct {
        logic [15:0] phy_data;
        logic [15:0] exp_bmsr;
        logic        exp_link;
    } rd_vec_t;
    rd_vec_t tbl [5];

    localparam logic [63:0] EXP_WR     = {32'hFFFF_FFFF, 2'b01, 2'b01, 5'd3, 5'd0, 2'b10, 16'h1200};
    localparam logic [45:0] EXP_RD_HDR = {32'hFFFF_FFFF, 2'b01, 2'b10, 5'd3, 5'd1};
    localparam logic [63:0] EXP_RD_OE  = {{46{1'b1}}, {18{1'b0}}};

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic timeout(input string name);
        checks++;
        errors++;
        $display("FAIL %s: timed out waiting for DUT", name);
    endtask

    // Waits for the next completed 64-bit frame, as seen by the monitor.
    task automatic wait_frame(input string name);
        int saved, n;
        saved = frame_cnt;
        n = 0;
        while (frame_cnt == saved && n < 1000) begin
            tick();
            n++;
        end
        if (frame_cnt == saved) timeout(name);
    endtask

    // Checks the reset-pin pulse width and the delay to the first MDC rise.
    task automatic check_power_up(input string tag);
        int n, m;
        n = 0;
        while (!phy_reset_n && n < 100) begin
            tick();
            n++;
        end
        chk({tag, " reset_n low clks"}, 64'(n), 64'd10);
        m = 0;
        while (!mdc && m < 100) begin
            tick();
            m++;
        end
        checks++;
        if (m < 22 || m > 24) begin
            errors++;
            $display("FAIL %s first mdc rise: got %0d clks, expected 22..24", tag, m);
        end
    endtask

    // Checks the write frame contents and that cfg_done rises only after the idle bit.
    task automatic check_write(input string tag);
        wait_frame({tag, " write frame"});
        chk({tag, " write bits"}, last_o, EXP_WR);
        chk({tag, " write oe"}, last_oe, 64'hFFFF_FFFF_FFFF_FFFF);
        repeat (3 * D - 1) tick();
        chk({tag, " cfg_done before idle end"}, 64'(cfg_done), 64'd0);
        tick();
        chk({tag, " cfg_done after idle"}, 64'(cfg_done), 64'd1);
        chk({tag, " idle pins"}, {61'd0, mdc, mdio_oe, mdio_o}, 64'd1);
    endtask

    initial begin
        int n;
        logic [15:0] prev_bmsr;

        tbl[0] = '{16'h786D, 16'h786D, 1'b1};
        tbl[1] = '{16'h7869, 16'h7869, 1'b0};
        tbl[2] = '{16'h0004, 16'h0004, 1'b1};
        tbl[3] = '{16'hFFFB, 16'hFFFB, 1'b0};
        tbl[4] = '{16'h786D, 16'h786D, 1'b1};

        rst = 1'b1;
        restart = 1'b0;
        repeat (3) tick();
        chk("rst phy_reset_n", 64'(phy_reset_n), 64'd0);
        chk("rst mdc", 64'(mdc), 64'd0);
        chk("rst mdio_o", 64'(mdio_o), 64'd1);
        chk("rst mdio_oe", 64'(mdio_oe), 64'd0);
        chk("rst cfg_done", 64'(cfg_done), 64'd0);
        chk("rst link_up", 64'(link_up), 64'd0);
        chk("rst bmsr", 64'(bmsr), 64'd0);

        rst = 1'b0;
        check_power_up("boot");
        check_write("boot");

        prev_bmsr = 16'h0000;
        for (int i = 0; i < 5; i++) begin
            phy_data = tbl[i].phy_data;
            wait_frame($sformatf("read%0d frame", i));
            chk($sformatf("read%0d header", i), 64'(last_o[63:18]), 64'(EXP_RD_HDR));
            chk($sformatf("read%0d oe", i), last_oe, EXP_RD_OE);
            chk($sformatf("read%0d start gap", i), 64'(rise0_last - rise0_prev), 64'd310);
            repeat (3 * D - 1) tick();
            chk($sformatf("read%0d bmsr early", i), 64'(bmsr), 64'(prev_bmsr));
            tick();
            chk($sformatf("read%0d bmsr", i), 64'(bmsr), 64'(tbl[i].exp_bmsr));
            chk($sformatf("read%0d link", i), 64'(link_up), 64'(tbl[i].exp_link));
            prev_bmsr = tbl[i].exp_bmsr;
        end

        // Restart in the middle of a read frame, just after the bit-52 MDC rise.
        phy_data = 16'h0000;
        n = 0;
        while (!(idx == 52 && gap == 0) && n < 1000) begin
            tick();
            n++;
        end
        if (n >= 1000) timeout("bit52 wait");
        restart = 1'b1;
        tick();
        restart = 1'b0;
        chk("restart mdio_oe", 64'(mdio_oe), 64'd0);
        chk("restart mdc", 64'(mdc), 64'd0);
        chk("restart phy_reset_n", 64'(phy_reset_n), 64'd0);
        chk("restart link_up", 64'(link_up), 64'd0);
        chk("restart cfg_done", 64'(cfg_done), 64'd0);
        chk("restart bmsr kept", 64'(bmsr), 64'h786D);

        check_power_up("rerun");
        check_write("rerun");
        chk("rerun bmsr kept", 64'(bmsr), 64'h786D);
        phy_data = 16'h7869;
        wait_frame("rerun read frame");
        repeat (3 * D) tick();
        chk("rerun read bmsr", 64'(bmsr), 64'h7869);
        chk("rerun read link", 64'(link_up), 64'd0);

        // Instance with POLL_CYCLES=0: frames are separated only by the idle bit.
        chk("poll0 write-read gap", 64'(starts2[1] - starts2[0]), 64'd260);
        chk("poll0 read-read gap", 64'(starts2[2] - starts2[1]), 64'd260);
        chk("poll0 bmsr", 64'(bmsr2), 64'hFFFF);
        chk("poll0 link", 64'(link_up2), 64'd1);

        // rst takes priority over a simultaneous restart and also clears o_bmsr.
        rst = 1'b1;
        restart = 1'b1;
        tick();
        rst = 1'b0;
        restart = 1'b0;
        chk("rst+restart bmsr", 64'(bmsr), 64'd0);
        chk("rst+restart phy_reset_n", 64'(phy_reset_n), 64'd0);
        chk("rst+restart cfg_done", 64'(cfg_done), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
